bcd_to_binary_seq: RTL and testbench
====================================

BCD_TO_BINARY_SEQ -- requirements
Module: bcd_to_binary_seq

Interface
REQ-001: Parameter DIGITS, default 4, number of packed BCD digits per input word; legal range 1..8.
REQ-002: Parameter BIN_W, default 14, width of binary result; shall be >= ceil(log2(10^DIGITS)) for exact results.
REQ-003: clk  input  1  single clock; all logic on rising edge.
REQ-004: rst  input  1  reset, synchronous and active-high.
REQ-005: in_valid  input  1  bcd_in holds a word to convert.
REQ-006: in_ready  output  1  block can accept a word this cycle.
REQ-007: bcd_in  input  4*DIGITS  packed BCD; digit k at bits [4k+3:4k], digit 0 least significant.
REQ-008: out_valid  output  1  bin_out/err hold a completed result.
REQ-009: out_ready  input  1  consumer accepts the result this cycle.
REQ-010: bin_out  output  BIN_W  binary value of the accepted BCD word.
REQ-011: err  output  1  accepted word contained a digit > 9 (see Configuration).
REQ-012: busy  output  1  high in CONV and DONE states.

Function
REQ-013: FSM states IDLE, CONV, DONE; in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state!=IDLE).
REQ-014: Input accepted in cycle where in_valid && in_ready; on that edge bcd_in is latched into a shift register, accumulator cleared, digit counter set to DIGITS-1, state -> CONV.
REQ-015: CONV: one digit per cycle, most significant first; acc <= acc*10 + digit, computed modulo 2^BIN_W.
REQ-016: CONV -> DONE on the edge that processes digit 0; exactly DIGITS cycles spent in CONV.
REQ-017: Accept in cycle 0 -> out_valid first high in cycle DIGITS+1.
REQ-018: DONE: bin_out and err held stable while out_valid && !out_ready; no change on any input.
REQ-019: out_valid && out_ready -> state IDLE next cycle; no same-cycle new accept (throughput 1 word per DIGITS+2 cycles minimum).
REQ-020: in_valid ignored outside IDLE; bcd_in changes outside the accept cycle have no effect.
REQ-021: bin_out and err outside DONE are don't-care for consumers but shall be 0 after reset until first result.
REQ-022: BIN_W below the exact width: result silently truncated modulo 2^BIN_W; no error flagged.

Reset
REQ-023: rst high at a clock edge -> state IDLE, in_ready=1, out_valid=0, busy=0, bin_out=0, err=0, accumulator/counter/shift register cleared.
REQ-024: rst mid-CONV or mid-DONE aborts the conversion; partial result discarded, never presented.
REQ-025: rst has priority over all handshakes in the same cycle.

Configuration
REQ-026: Macro BCD2BIN_ERR_CHECK_EN defined: each digit > 9 in CONV sets a sticky error bit; in DONE err=1 and bin_out=0 for that word.
REQ-027: Macro BCD2BIN_ERR_CHECK_EN undefined: err tied to 0; digits 10..15 used arithmetically as-is (e.g. digit A weighted as 10).

Verification
REQ-028: DIGITS=4, BIN_W=14, bcd_in=16'h1234 accepted cycle 0, out_ready=1 -> out_valid cycle 5, bin_out=1234 (0x4D2), err=0, in_ready high cycle 6.
REQ-029: bcd_in=16'h9999 -> bin_out=9999 (0x270F); bcd_in=16'h0000 -> bin_out=0; both err=0.
REQ-030: Backpressure: 16'h0042 accepted, out_ready low 10 cycles after out_valid -> bin_out=42 held stable, in_ready=0 throughout, in_valid pulses ignored; release -> IDLE next cycle.
REQ-031: 16'h12A4 with BCD2BIN_ERR_CHECK_EN -> err=1, bin_out=0; without macro -> err=0, bin_out=1304 (1*1000+2*100+10*10+4).
REQ-032: rst asserted in cycle 2 of CONV for 16'h5678 -> next cycle all outputs at reset values; following word 16'h0007 -> bin_out=7, no residue.
REQ-033: Back-to-back: 16'h0001 then 16'h0002 with in_valid held high, out_ready=1 -> results 1 then 2, second out_valid DIGITS+2=6 cycles after first.

Source files
------------

// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to binary converter: one digit per cycle, most significant digit first.
// Optional macro BCD2BIN_ERR_CHECK_EN: flag words containing a digit above 9 (err=1, bin_out=0).
module bcd_to_binary_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] bcd_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BIN_W-1:0]    bin_out,
    output logic                err,
    output logic                busy
);
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] shreg_q, shreg_d;
    logic [BIN_W-1:0]    acc_q, acc_d;
    logic [BIN_W-1:0]    res_q, res_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [3:0]          digit;
    logic [BIN_W-1:0]    acc_step;

    // acc*10 + digit as (acc<<3)+(acc<<1)+digit; wraps modulo 2^BIN_W by construction
    assign digit    = shreg_q[4*DIGITS-1 -: 4];
    assign acc_step = (acc_q << 3) + (acc_q << 1) + BIN_W'(digit);

`ifdef BCD2BIN_ERR_CHECK_EN
    logic sticky_q, sticky_d;
    logic err_q, err_d;
    logic word_bad;

    assign word_bad = sticky_q | (digit > 4'd9);
    assign err      = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign bin_out   = res_q;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
`ifdef BCD2BIN_ERR_CHECK_EN
        sticky_d = sticky_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = CONV;
                    shreg_d = bcd_in;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(DIGITS - 1);
`ifdef BCD2BIN_ERR_CHECK_EN
                    sticky_d = 1'b0;
`endif
                end
            end
            CONV: begin
                shreg_d = shreg_q << 4;
                acc_d   = acc_step;
                cnt_d   = cnt_q - CNT_W'(1);
`ifdef BCD2BIN_ERR_CHECK_EN
                sticky_d = word_bad;
`endif
                if (cnt_q == '0) begin
                    state_d = DONE;
                    res_d   = acc_step;
`ifdef BCD2BIN_ERR_CHECK_EN
                    err_d = word_bad;
                    if (word_bad) begin
                        res_d = '0;
                    end
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
`ifdef BCD2BIN_ERR_CHECK_EN
            sticky_q <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
`ifdef BCD2BIN_ERR_CHECK_EN
            sticky_q <= sticky_d;
            err_q    <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: vector table, scoreboard queue, hand-written corner sequences.
module tb_bcd_to_binary_seq;
    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;
    localparam int NVEC   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       bcd_in;
    logic              out_valid;
    logic              out_ready;
    logic [BIN_W-1:0]  bin_out;
    logic              err;
    logic              busy;

    always #5 clk = ~clk;

    bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .err       (err),
        .busy      (busy)
    );

    typedef struct {
        logic [15:0]      bcd;
        logic [BIN_W-1:0] bin;
        logic             err;
    } vec_t;

    typedef struct {
        logic [BIN_W-1:0] bin;
        logic             err;
    } exp_t;

    vec_t vt [0:NVEC-1];
    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   n_txn  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Scoreboard: every completed output handshake pops one expected result
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL sb_underflow: got bin_out=%0d with no expected entry", bin_out);
            end else begin
                mon_e = sb_q.pop_front();
                n_txn++;
                $display("txn %0d: bin_out=%0d err=%0b (expected %0d/%0b)",
                         n_txn, bin_out, err, mon_e.bin, mon_e.err);
                check("bin_out", 32'(bin_out), 32'(mon_e.bin));
                check("err", 32'(err), 32'(mon_e.err));
            end
        end
    end

    // Entered and left just after a rising edge; returns just after the accepting edge
    task automatic send(input logic [15:0] w, input logic push,
                        input logic [BIN_W-1:0] eb, input logic ee);
        int t;
        in_valid = 1'b1;
        bcd_in   = w;
        for (t = 0; t < 40; t++) begin
            @(negedge clk);
            if (in_ready) break;
            @(posedge clk); #1;
        end
        if (t == 40) begin
            n_vec++;
            n_miss++;
            $display("FAIL send_timeout: in_ready got 0, expected 1");
        end
        if (push) sb_q.push_back('{eb, ee});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts falling edges after acceptance until out_valid; stops on that falling edge
    task automatic wait_out(output int lat);
        int c;
        c = 0;
        while (1) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                check("busy_in_conv", 32'(busy), 32'd1);
                check("in_ready_in_conv", 32'(in_ready), 32'd0);
            end
            if (out_valid) break;
            if (c >= 40) begin
                n_vec++;
                n_miss++;
                $display("FAIL out_timeout: out_valid got 0, expected 1");
                break;
            end
        end
        lat = c;
    endtask

    task automatic run_vec(input logic [15:0] w, input logic [BIN_W-1:0] eb, input logic ee);
        int lat;
        send(w, 1'b1, eb, ee);
        wait_out(lat);
        check("latency", 32'(lat), 32'(DIGITS + 1));
        @(posedge clk); #1;
        @(negedge clk);
        check("in_ready_after", 32'(in_ready), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        int t1;
        int t2;
        int pushed;

        vt[0] = '{16'h1234, 14'd1234, 1'b0};
        vt[1] = '{16'h9999, 14'd9999, 1'b0};
        vt[2] = '{16'h0000, 14'd0,    1'b0};
`ifdef BCD2BIN_ERR_CHECK_EN
        vt[3] = '{16'h12A4, 14'd0,    1'b1};
        vt[7] = '{16'hFFFF, 14'd0,    1'b1};
`else
        vt[3] = '{16'h12A4, 14'd1304, 1'b0};
        vt[7] = '{16'hFFFF, 14'd281,  1'b0};
`endif
        vt[4] = '{16'h0001, 14'd1,    1'b0};
        vt[5] = '{16'h9000, 14'd9000, 1'b0};
        vt[6] = '{16'h0909, 14'd909,  1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        bcd_in    = 16'h0000;
        @(posedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bin_out", 32'(bin_out), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vt[i].bcd, vt[i].bin, vt[i].err);
        end

        // Backpressure: result held for 10 cycles, in_valid pulses ignored
        out_ready = 1'b0;
        send(16'h0042, 1'b1, 14'd42, 1'b0);
        wait_out(lat);
        check("bp_latency", 32'(lat), 32'(DIGITS + 1));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = (i % 2 == 0);
            bcd_in   = 16'h9999;
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_bin_out", 32'(bin_out), 32'd42);
            check("bp_err", 32'(err), 32'd0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Reset during the second CONV cycle discards the word
        send(16'h5678, 1'b0, 14'd0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_bin_out", 32'(bin_out), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midrst_no_output", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        run_vec(16'h0007, 14'd7, 1'b0);

        // Back-to-back with in_valid held high
        in_valid = 1'b1;
        bcd_in   = 16'h0001;
        pushed   = 0;
        t1       = -1;
        t2       = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) begin
                if (t1 < 0) t1 = c;
                else if (t2 < 0) t2 = c;
            end
            if (in_ready && in_valid) begin
                pushed++;
                sb_q.push_back('{BIN_W'(pushed), 1'b0});
            end
            @(posedge clk); #1;
            if (pushed == 1) bcd_in = 16'h0002;
            if (pushed >= 2) in_valid = 1'b0;
            if (t2 >= 0) break;
        end
        check("b2b_gap", 32'(t2 - t1), 32'(DIGITS + 2));
        check("b2b_accepts", 32'(pushed), 32'd2);

        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(posedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
